// File: rtl/ifetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: data widths, the default
// reset PC, the fetch FSM state encoding and a small opcode helper.
package ifetch_unit_pkg;

   localparam int OP_W   = 6;
   localparam int WORD_W = 32;

   localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef enum logic {
      FETCH = 1'b0,
      HOLD  = 1'b1
   } fetch_state_t;

   // Primary opcode field of an instruction word
   function automatic logic [OP_W-1:0] opcode_of(input logic [WORD_W-1:0] word);
      return word[WORD_W-1 -: OP_W];
   endfunction

endpackage

// File: rtl/ifetch_unit_if.sv
// Instruction memory read bus: the fetch unit is the master, memory the slave.
interface ifetch_unit_if;
   import ifetch_unit_pkg::*;

   logic              imem_req;
   logic [WORD_W-1:0] imem_addr;
   logic              imem_ack;
   logic [WORD_W-1:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_rdata
   );

endinterface

// File: rtl/ifetch_unit_npc_calc.sv
// Combinational next-PC selector for the held instruction: jump beats a taken
// branch, which beats the sequential pc+4. All arithmetic wraps at 2^32.
module ifetch_unit_npc_calc
   import ifetch_unit_pkg::*;
(
   input  logic [WORD_W-1:0] pc,
   input  logic [25:0]       instr_idx,
   input  logic              branch_eq,
   input  logic              branch_ne,
   input  logic              jump,
   input  logic              zero,
   output logic [WORD_W-1:0] pc_next
);

   logic [WORD_W-1:0] pc_plus4;
   logic [WORD_W-1:0] branch_off;
   logic [WORD_W-1:0] branch_target;
   logic [WORD_W-1:0] jump_target;
   logic              branch_taken;

   assign pc_plus4      = pc + 32'd4;
   assign branch_off    = {{14{instr_idx[15]}}, instr_idx[15:0], 2'b00};
   assign branch_target = pc_plus4 + branch_off;
   assign jump_target   = {pc_plus4[31:28], instr_idx, 2'b00};
   assign branch_taken  = (branch_eq & zero) | (branch_ne & ~zero);

   // Pick the redirect target by priority, defaulting to sequential flow
   always_comb begin
      pc_next = pc_plus4;
      if (jump) begin
         pc_next = jump_target;
      end else if (branch_taken) begin
         pc_next = branch_target;
      end
   end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: fetches one word, holds it for downstream until it
// is retired, then fetches from the computed next PC. One instruction is in
// flight at a time.
module ifetch_unit
   import ifetch_unit_pkg::*;
#(
   parameter logic [WORD_W-1:0] RESET_PC          = RESET_PC_DEFAULT,
   parameter logic [WORD_W-1:0] RETIRED_CNT_RESET = '0
)
(
   input  logic              clk,
   input  logic              rst_n,
   ifetch_unit_if.master     imem,
   output logic [WORD_W-1:0] instr,
   output logic [OP_W-1:0]   op,
   output logic [WORD_W-1:0] pc,
   output logic              instr_valid,
   input  logic              instr_taken,
   input  logic              branch_eq,
   input  logic              branch_ne,
   input  logic              jump,
   input  logic              zero,
   output logic [WORD_W-1:0] retired_cnt
);

   fetch_state_t      state;
   fetch_state_t      state_nxt;
   logic              req_en;
   logic              fetch_req;
   logic              fetch_done;
   logic              retire;
   logic [WORD_W-1:0] pc_next_reg;
   logic [WORD_W-1:0] npc;

   ifetch_unit_npc_calc u_npc (
      .pc        (pc),
      .instr_idx (instr[25:0]),
      .branch_eq (branch_eq),
      .branch_ne (branch_ne),
      .jump      (jump),
      .zero      (zero),
      .pc_next   (npc)
   );

   assign imem.imem_req  = fetch_req;
   assign imem.imem_addr = pc_next_reg;
   assign op             = opcode_of(instr);
   assign fetch_done     = fetch_req & imem.imem_ack;
   assign retire         = instr_valid & instr_taken;

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= FETCH;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and per-state outputs; the request is gated by the registered
   // enable so nothing is requested (or accepted) until a clock after reset
   always_comb begin
      state_nxt   = state;
      fetch_req   = 1'b0;
      instr_valid = 1'b0;
      case (state)
         FETCH: begin
            fetch_req = req_en;
            if (req_en && imem.imem_ack) begin
               state_nxt = HOLD;
            end
         end
         HOLD: begin
            instr_valid = 1'b1;
            if (instr_taken) begin
               state_nxt = FETCH;
            end
         end
         default: begin
            state_nxt = FETCH;
         end
      endcase
   end

   // Request enable rises on the first clock after reset release
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_en <= 1'b0;
      end else begin
         req_en <= 1'b1;
      end
   end

   // Capture the fetched word and its address when memory answers a request
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr <= '0;
         pc    <= RESET_PC;
      end else if (fetch_done) begin
         instr <= imem.imem_rdata;
         pc    <= pc_next_reg;
      end
   end

   // On retirement, advance the fetch address and count the instruction
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_next_reg <= RESET_PC;
         retired_cnt <= RETIRED_CNT_RESET;
      end else if (retire) begin
         pc_next_reg <= npc;
         retired_cnt <= retired_cnt + 32'd1;
      end
   end

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: a table of directed instructions, a few
// multi-cycle reset/stall sequences, a randomized run against an arithmetic
// next-PC model, and a second instance that starts near the wrap points.
module tb_ifetch_unit;

   logic        clk;
   logic        rst_n;
   logic        rst_w_n;
   logic        instr_taken;
   logic        branch_eq;
   logic        branch_ne;
   logic        jump;
   logic        zero;
   logic [31:0] instr;
   logic [5:0]  op;
   logic [31:0] pc;
   logic        instr_valid;
   logic [31:0] retired_cnt;

   logic [31:0] w_instr;
   logic [5:0]  w_op;
   logic [31:0] w_pc;
   logic        w_valid;
   logic        w_taken;
   logic [31:0] w_cnt;

   int checks = 0;
   int errors = 0;

   ifetch_unit_if bus ();
   ifetch_unit_if wbus ();

   ifetch_unit dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .imem        (bus),
      .instr       (instr),
      .op          (op),
      .pc          (pc),
      .instr_valid (instr_valid),
      .instr_taken (instr_taken),
      .branch_eq   (branch_eq),
      .branch_ne   (branch_ne),
      .jump        (jump),
      .zero        (zero),
      .retired_cnt (retired_cnt)
   );

   // Free-running instance: zero-wait memory of zero words, always retires
   assign wbus.imem_ack   = wbus.imem_req;
   assign wbus.imem_rdata = 32'h0000_0000;
   assign w_taken         = w_valid;

   ifetch_unit #(
      .RESET_PC          (32'hFFFF_FFFC),
      .RETIRED_CNT_RESET (32'hFFFF_FFFE)
   ) dut_w (
      .clk         (clk),
      .rst_n       (rst_w_n),
      .imem        (wbus),
      .instr       (w_instr),
      .op          (w_op),
      .pc          (w_pc),
      .instr_valid (w_valid),
      .instr_taken (w_taken),
      .branch_eq   (1'b0),
      .branch_ne   (1'b0),
      .jump        (1'b0),
      .zero        (1'b0),
      .retired_cnt (w_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] word;
      logic        beq;
      logic        bne;
      logic        jmp;
      logic        z;
      logic [31:0] exp_addr;
      logic [5:0]  exp_op;
      logic [31:0] exp_next;
   } vec_t;

   vec_t vecs [13];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic ack, input logic [31:0] rdata, input logic taken,
                                input logic beq, input logic bne, input logic jmp, input logic z);
      bus.imem_ack   = ack;
      bus.imem_rdata = rdata;
      instr_taken    = taken;
      branch_eq      = beq;
      branch_ne      = bne;
      jump           = jmp;
      zero           = z;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   // Reference next PC computed from the instruction-set rules with plain
   // 64-bit arithmetic and explicit modulo reduction
   function automatic logic [31:0] refNextPc(input logic [31:0] cur, input logic [31:0] w,
                                             input logic beq, input logic bne, input logic jmp,
                                             input logic z);
      longint base;
      longint tgt;
      longint imm;
      base = (longint'(cur) + 64'd4) % (64'd1 << 32);
      imm  = longint'($signed(w[15:0]));
      if (jmp) begin
         tgt = (base - (base % (64'd1 << 28))) + (longint'(w) % (64'd1 << 26)) * 4;
      end else if ((beq && z) || (bne && !z)) begin
         tgt = (base + imm * 4 + (64'd1 << 32)) % (64'd1 << 32);
      end else begin
         tgt = base;
      end
      return tgt[31:0];
   endfunction

   // Assert reset, check the reset image, release and check the delayed request
   task automatic doReset(input string tag);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b0;
      #1;
      checkOutput({tag, ".rst_req"},   32'(bus.imem_req), 32'd0);
      checkOutput({tag, ".rst_addr"},  bus.imem_addr, 32'h0);
      checkOutput({tag, ".rst_instr"}, instr, 32'h0);
      checkOutput({tag, ".rst_pc"},    pc, 32'h0);
      checkOutput({tag, ".rst_valid"}, 32'(instr_valid), 32'd0);
      checkOutput({tag, ".rst_cnt"},   retired_cnt, 32'h0);
      tick();
      tick();
      rst_n = 1'b1;
      #1;
      checkOutput({tag, ".rel_req0"}, 32'(bus.imem_req), 32'd0);
      tick();
      checkOutput({tag, ".rel_req1"}, 32'(bus.imem_req), 32'd1);
      checkOutput({tag, ".rel_addr"}, bus.imem_addr, 32'h0);
   endtask

   // One complete fetch/hold/retire round with optional stall, hold delay and
   // spurious acks while holding
   task automatic doInstr(input string tag, input logic [31:0] word,
                          input logic beq, input logic bne, input logic jmp, input logic z,
                          input int stall, input int holdWait, input bit spurious,
                          input logic [31:0] expAddr, input logic [5:0] expOp,
                          input logic [31:0] expNext, input logic [31:0] expCnt);
      for (int s = 0; s < stall; s++) begin
         applyStimulus(1'b0, $urandom(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         checkOutput({tag, ".stall_req"},  32'(bus.imem_req), 32'd1);
         checkOutput({tag, ".stall_addr"}, bus.imem_addr, expAddr);
         tick();
      end
      applyStimulus(1'b1, word, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput({tag, ".fetch_req"},   32'(bus.imem_req), 32'd1);
      checkOutput({tag, ".fetch_addr"},  bus.imem_addr, expAddr);
      checkOutput({tag, ".fetch_valid"}, 32'(instr_valid), 32'd0);
      checkOutput({tag, ".fetch_cnt"},   retired_cnt, expCnt - 32'd1);
      tick();
      applyStimulus(1'b0, ~word, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput({tag, ".hold_valid"}, 32'(instr_valid), 32'd1);
      checkOutput({tag, ".hold_instr"}, instr, word);
      checkOutput({tag, ".hold_op"},    32'(op), 32'(expOp));
      checkOutput({tag, ".hold_pc"},    pc, expAddr);
      checkOutput({tag, ".hold_req"},   32'(bus.imem_req), 32'd0);
      for (int h = 0; h < holdWait; h++) begin
         applyStimulus(spurious, ~word, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         tick();
         checkOutput({tag, ".wait_instr"}, instr, word);
         checkOutput({tag, ".wait_valid"}, 32'(instr_valid), 32'd1);
         checkOutput({tag, ".wait_pc"},    pc, expAddr);
      end
      applyStimulus(1'b0, ~word, 1'b1, beq, bne, jmp, z);
      tick();
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput({tag, ".ret_cnt"},   retired_cnt, expCnt);
      checkOutput({tag, ".ret_valid"}, 32'(instr_valid), 32'd0);
      checkOutput({tag, ".ret_req"},   32'(bus.imem_req), 32'd1);
      checkOutput({tag, ".ret_next"},  bus.imem_addr, expNext);
   endtask

   initial begin
      logic [31:0] modelPc;
      logic [31:0] modelCnt;
      logic [31:0] word;
      logic [31:0] expNext;
      logic        rb;
      logic        rn;
      logic        rj;
      logic        rz;

      //            word          beq   bne   jmp   z     addr          op     next
      vecs[0]  = '{32'h2008_0005, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 6'h08, 32'h0000_0004};
      vecs[1]  = '{32'h0800_0040, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0004, 6'h02, 32'h0000_0100};
      vecs[2]  = '{32'h1000_FFFE, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0100, 6'h04, 32'h0000_00FC};
      vecs[3]  = '{32'h0800_0040, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_00FC, 6'h02, 32'h0000_0100};
      vecs[4]  = '{32'h1000_FFFE, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0100, 6'h04, 32'h0000_0104};
      vecs[5]  = '{32'h0BFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0104, 6'h02, 32'h0FFF_FFFC};
      vecs[6]  = '{32'h0800_0004, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0FFF_FFFC, 6'h02, 32'h1000_0010};
      vecs[7]  = '{32'h0800_0040, 1'b0, 1'b1, 1'b1, 1'b0, 32'h1000_0010, 6'h02, 32'h1000_0100};
      vecs[8]  = '{32'h1400_0010, 1'b1, 1'b1, 1'b0, 1'b0, 32'h1000_0100, 6'h05, 32'h1000_0144};
      vecs[9]  = '{32'h1000_FFFF, 1'b1, 1'b1, 1'b0, 1'b1, 32'h1000_0144, 6'h04, 32'h1000_0144};
      vecs[10] = '{32'h1400_FFFF, 1'b0, 1'b1, 1'b0, 1'b1, 32'h1000_0144, 6'h05, 32'h1000_0148};
      vecs[11] = '{32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h1000_0148, 6'h00, 32'h1000_014C};
      vecs[12] = '{32'h0800_0000, 1'b1, 1'b0, 1'b1, 1'b1, 32'h1000_014C, 6'h02, 32'h1000_0000};

      rst_w_n = 1'b0;
      rst_n   = 1'b1;
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      #2;

      doReset("init");

      for (int i = 0; i < 13; i++) begin
         doInstr($sformatf("vec%0d", i), vecs[i].word, vecs[i].beq, vecs[i].bne, vecs[i].jmp,
                 vecs[i].z, (i == 0) ? 0 : (i % 3), i % 2, (i % 2) == 1,
                 vecs[i].exp_addr, vecs[i].exp_op, vecs[i].exp_next, 32'(i + 1));
      end

      $display("[TB] long stall with spurious acks while holding");
      doInstr("stall5", 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 5, 3, 1'b1,
              32'h1000_0000, 6'h00, 32'h1000_0004, 32'd14);

      $display("[TB] reset during fetch with a late ack");
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b0;
      #1;
      checkOutput("midfetch.rst_req",  32'(bus.imem_req), 32'd0);
      checkOutput("midfetch.rst_addr", bus.imem_addr, 32'h0);
      checkOutput("midfetch.rst_cnt",  retired_cnt, 32'h0);
      tick();
      applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;
      tick();
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("midfetch.late_valid", 32'(instr_valid), 32'd0);
      checkOutput("midfetch.late_instr", instr, 32'h0);
      checkOutput("midfetch.late_req",   32'(bus.imem_req), 32'd1);
      checkOutput("midfetch.late_addr",  bus.imem_addr, 32'h0);
      checkOutput("midfetch.late_cnt",   retired_cnt, 32'h0);

      $display("[TB] reset while holding");
      applyStimulus(1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      checkOutput("midhold.valid", 32'(instr_valid), 32'd1);
      checkOutput("midhold.instr", instr, 32'h1234_5678);
      doReset("midhold");

      $display("[TB] randomized run against reference model");
      modelPc  = 32'h0;
      modelCnt = 32'h0;
      for (int n = 0; n < 200; n++) begin
         word     = $urandom();
         rb       = 1'($urandom_range(0, 1));
         rn       = 1'($urandom_range(0, 1));
         rj       = 1'($urandom_range(0, 3) == 0);
         rz       = 1'($urandom_range(0, 1));
         expNext  = refNextPc(modelPc, word, rb, rn, rj, rz);
         modelCnt = modelCnt + 32'd1;
         doInstr($sformatf("rnd%0d", n), word, rb, rn, rj, rz,
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                 modelPc, 6'(word >> 26), expNext, modelCnt);
         modelPc = expNext;
      end

      $display("[TB] address and counter wrap on second instance");
      checkOutput("wrap.rst_cnt", w_cnt, 32'hFFFF_FFFE);
      checkOutput("wrap.rst_req", 32'(wbus.imem_req), 32'd0);
      rst_w_n = 1'b1;
      #1;
      checkOutput("wrap.rel_req0", 32'(wbus.imem_req), 32'd0);
      tick();
      checkOutput("wrap.req1",  32'(wbus.imem_req), 32'd1);
      checkOutput("wrap.addr1", wbus.imem_addr, 32'hFFFF_FFFC);
      tick();
      checkOutput("wrap.valid1", 32'(w_valid), 32'd1);
      checkOutput("wrap.pc1",    w_pc, 32'hFFFF_FFFC);
      checkOutput("wrap.instr1", w_instr, 32'h0);
      checkOutput("wrap.op1",    32'(w_op), 32'd0);
      tick();
      checkOutput("wrap.addr2", wbus.imem_addr, 32'h0000_0000);
      checkOutput("wrap.cnt2",  w_cnt, 32'hFFFF_FFFF);
      tick();
      checkOutput("wrap.pc2", w_pc, 32'h0000_0000);
      tick();
      checkOutput("wrap.cnt3",  w_cnt, 32'h0000_0000);
      checkOutput("wrap.addr3", wbus.imem_addr, 32'h0000_0004);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
